parity_checker: RTL and testbench

- Receive-side companion to the parity generator: accepts a data word plus its parity bit on a valid/ready stream and recomputes parity.
- Forwards the word downstream with a per-word error flag, and keeps a sticky error flag and a saturating error counter for status readout.
- Sits between a link/bus receiver and the consuming logic; a two-entry skid buffer gives full throughput with registered outputs.

---
 rtl/parity_pkg.sv | 21 ++
 rtl/parity_checker_if.sv | 24 ++
 rtl/parity_checker_skid_buffer.sv | 71 +++++++
 rtl/parity_checker.sv | 76 +++++++
 tb/tb_parity_checker.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/parity_pkg.sv
// Shared parity definitions for the parity generator and the parity checker.
// Holds the parity-sense encodings, the skid-buffer state type and parity_of().
package parity_pkg;

  localparam int PAR_EVEN  = 0;
  localparam int PAR_ODD   = 1;

  // Widest word parity_of() accepts; callers zero-extend, which leaves the XOR unchanged.
  localparam int PAR_MAX_W = 256;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  function automatic logic parity_of(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/parity_checker_if.sv
// Stream bundle around the parity checker: upstream word+parity in, checked word+flag out.
// master = the surrounding logic, slave = the checker.
interface parity_checker_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_parity;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_error;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_parity, in_valid, out_ready,
    input  in_ready, out_data, out_error, out_valid
  );

  modport slave (
    input  in_data, in_parity, in_valid, out_ready,
    output in_ready, out_data, out_error, out_valid
  );
endinterface

// File: rtl/parity_checker_skid_buffer.sv
// skid_buffer: two-entry valid/ready buffer (head register drives the output,
// skid register catches the word arriving while the head is stalled).
// s_ready is a pure decode of the state register, so it never depends on s_valid.
module skid_buffer
  import parity_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  buf_state_t       state;
  buf_state_t       state_nxt;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] skid;
  logic             push;
  logic             pop;

  assign push   = s_valid & s_ready;
  assign pop    = m_valid & m_ready;
  assign m_data = head;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next-state: occupancy moves by +1 on push only, -1 on pop only.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = TWO;
        else if (pop && !push) state_nxt = EMPTY;
      end
      TWO:     if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    s_ready = (state != TWO);
    m_valid = (state != EMPTY);
  end

  // Data path: head loads new input when free or draining, skid catches the overflow word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (state == TWO) begin
        if (pop) head <= skid;
      end else if (push && ((state == EMPTY) || pop)) begin
        head <= s_data;
      end
      if (push && (state == ONE) && !pop) skid <= s_data;
    end
  end

endmodule

// File: rtl/parity_checker.sv
// parity_checker: recomputes parity on each received word, forwards the word with a
// mismatch flag through a 2-entry skid buffer, and keeps sticky/counter error status.
// Build option PARITY_CHECKER_DROP_EN: mismatching words are accepted and counted
// but not forwarded; out_error then stays 0.
module parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ODD    = PAR_EVEN,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  parity_checker_if.slave  bus,
  input  logic             err_clear,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);

  localparam logic ODD_BIT = (ODD != PAR_EVEN);

  logic [PAR_MAX_W-1:0] data_ext;
  logic                 mis;
  logic                 keep;
  logic                 err_hit;
  logic [DATA_W:0]      buf_in;
  logic [DATA_W:0]      buf_out;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign data_ext = PAR_MAX_W'(bus.in_data);
  assign mis      = parity_of(data_ext) ^ bus.in_parity ^ ODD_BIT;
  assign err_hit  = bus.in_valid & bus.in_ready & mis;

`ifdef PARITY_CHECKER_DROP_EN
  // Bad words never enter the buffer, so the stored flag bit is constant 0.
  assign keep   = ~mis;
  assign buf_in = {bus.in_data, 1'b0};
`else
  assign keep   = 1'b1;
  assign buf_in = {bus.in_data, mis};
`endif

  skid_buffer #(
    .WIDTH (DATA_W + 1)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (buf_in),
    .s_valid (bus.in_valid & keep),
    .s_ready (bus.in_ready),
    .m_data  (buf_out),
    .m_valid (bus.out_valid),
    .m_ready (bus.out_ready)
  );

  assign bus.out_data  = buf_out[DATA_W:1];
  assign bus.out_error = buf_out[0];

  // Error status: a newly accepted bad word outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (err_hit) begin
      err_sticky <= 1'b1;
      err_count  <= err_clear ? CNT_W'(1) : sat_inc(err_count);
    end else if (err_clear) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end
  end

endmodule

// File: tb/tb_parity_checker.sv
// Bench for parity_checker: two instances (even parity / 8-bit counter, odd parity /
// 2-bit counter) share one stimulus stream; each is compared every cycle against a
// queue-based reference model. Honours PARITY_CHECKER_DROP_EN when defined.
module tb_parity_checker;

`ifdef PARITY_CHECKER_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } word_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       err_clear = 1'b0;
  logic       sticky0, sticky1;
  logic [7:0] count0;
  logic [1:0] count1;

  always #5 clk = ~clk;

  parity_checker_if #(.DATA_W(8)) bus0 ();
  parity_checker_if #(.DATA_W(8)) bus1 ();

  parity_checker #(.DATA_W(8), .ODD(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
    .err_clear(err_clear), .err_sticky(sticky0), .err_count(count0)
  );

  parity_checker #(.DATA_W(8), .ODD(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
    .err_clear(err_clear), .err_sticky(sticky1), .err_count(count1)
  );

  word_t q0[$];
  word_t q1[$];
  bit    stk0, stk1;
  int    cnt0, cnt1;
  int    n_vec = 0;
  int    n_bad = 0;

  // Word is bad when the total count of ones (data + parity bit) has the wrong sense.
  function automatic bit ref_mis(input logic [7:0] d, input logic p, input bit odd);
    int ones;
    ones = $countones(d) + int'(p);
    return ((ones % 2) != int'(odd));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_one(input string nm, input logic rdy, input logic vld,
                           input logic [7:0] d, input logic e, input logic stk,
                           input logic [7:0] cnt, input int n, input word_t head,
                           input bit estk, input int ecnt);
    chk({nm, ".in_ready"},  32'(rdy), 32'(n < 2));
    chk({nm, ".out_valid"}, 32'(vld), 32'(n > 0));
    if (n > 0) begin
      chk({nm, ".out_data"},  32'(d), 32'(head.d));
      chk({nm, ".out_error"}, 32'(e), 32'(head.e));
    end
    chk({nm, ".err_sticky"}, 32'(stk), 32'(estk));
    chk({nm, ".err_count"},  32'(cnt), 32'(ecnt));
  endtask

  task automatic check_all();
    check_one("u0", bus0.in_ready, bus0.out_valid, bus0.out_data, bus0.out_error,
              sticky0, count0, q0.size(), (q0.size() > 0) ? q0[0] : word_t'('0),
              stk0, cnt0);
    check_one("u1", bus1.in_ready, bus1.out_valid, bus1.out_data, bus1.out_error,
              sticky1, 8'(count1), q1.size(), (q1.size() > 0) ? q1[0] : word_t'('0),
              stk1, cnt1);
  endtask

  task automatic check_reset();
    chk("rst.u0.in_ready",  32'(bus0.in_ready),  32'd1);
    chk("rst.u0.out_valid", 32'(bus0.out_valid), 32'd0);
    chk("rst.u0.out_data",  32'(bus0.out_data),  32'd0);
    chk("rst.u0.out_error", 32'(bus0.out_error), 32'd0);
    chk("rst.u0.sticky",    32'(sticky0),        32'd0);
    chk("rst.u0.count",     32'(count0),         32'd0);
    chk("rst.u1.in_ready",  32'(bus1.in_ready),  32'd1);
    chk("rst.u1.out_valid", 32'(bus1.out_valid), 32'd0);
    chk("rst.u1.out_data",  32'(bus1.out_data),  32'd0);
    chk("rst.u1.sticky",    32'(sticky1),        32'd0);
    chk("rst.u1.count",     32'(count1),         32'd0);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    stk0 = 1'b0; stk1 = 1'b0;
    cnt0 = 0;    cnt1 = 0;
  endtask

  task automatic drive(input logic [7:0] d, input logic p, input logic v, input logic ordy);
    bus0.in_data = d; bus0.in_parity = p; bus0.in_valid = v; bus0.out_ready = ordy;
    bus1.in_data = d; bus1.in_parity = p; bus1.in_valid = v; bus1.out_ready = ordy;
  endtask

  // One clock: decide transfers from the model, advance it, then compare both DUTs.
  task automatic tick();
    bit    push0, push1, pop0, pop1, m0, m1, clr;
    word_t w0, w1;
    clr   = err_clear;
    m0    = ref_mis(bus0.in_data, bus0.in_parity, 1'b0);
    m1    = ref_mis(bus1.in_data, bus1.in_parity, 1'b1);
    push0 = bus0.in_valid && (q0.size() < 2);
    push1 = bus1.in_valid && (q1.size() < 2);
    pop0  = bus0.out_ready && (q0.size() > 0);
    pop1  = bus1.out_ready && (q1.size() > 0);
    w0    = {bus0.in_data, (DROP ? 1'b0 : m0)};
    w1    = {bus1.in_data, (DROP ? 1'b0 : m1)};
    @(posedge clk);
    #1;
    if (pop0) q0.delete(0);
    if (pop1) q1.delete(0);
    if (push0 && !(DROP && m0)) q0.push_back(w0);
    if (push1 && !(DROP && m1)) q1.push_back(w1);
    if (push0 && m0) begin
      stk0 = 1'b1;
      cnt0 = clr ? 1 : ((cnt0 < 255) ? cnt0 + 1 : 255);
    end else if (clr) begin
      stk0 = 1'b0; cnt0 = 0;
    end
    if (push1 && m1) begin
      stk1 = 1'b1;
      cnt1 = clr ? 1 : ((cnt1 < 3) ? cnt1 + 1 : 3);
    end else if (clr) begin
      stk1 = 1'b0; cnt1 = 0;
    end
    check_all();
  endtask

  initial begin
    model_reset();
    drive(8'h00, 1'b0, 1'b0, 1'b0);

    // Power-on reset.
    #2 rst_n = 1'b0;
    #1 check_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Back-to-back good words (even parity), full throughput.
    drive(8'h00, 1'b0, 1'b1, 1'b1); tick();
    drive(8'hFF, 1'b0, 1'b1, 1'b1); tick();
    drive(8'h01, 1'b1, 1'b1, 1'b1); tick();
    drive(8'h00, 1'b0, 1'b0, 1'b1); tick(); tick();

    // Single mismatch under even parity; good under odd parity.
    drive(8'h03, 1'b1, 1'b1, 1'b1); tick();
    drive(8'h00, 1'b0, 1'b0, 1'b1); tick(); tick();

    // Drop-feature stream: one bad word in the middle.
    drive(8'h01, 1'b1, 1'b1, 1'b1); tick();
    drive(8'h01, 1'b0, 1'b1, 1'b1); tick();
    drive(8'h02, 1'b1, 1'b1, 1'b1); tick();
    drive(8'h00, 1'b0, 1'b0, 1'b1); tick(); tick();

    // Backpressure: three words offered with the sink stalled, then release.
    drive(8'hA5, 1'b0, 1'b1, 1'b0); tick();
    drive(8'h5A, 1'b0, 1'b1, 1'b0); tick();
    drive(8'h3C, 1'b0, 1'b1, 1'b0); tick(); tick();
    drive(8'h3C, 1'b0, 1'b1, 1'b1); tick(); tick();
    drive(8'h00, 1'b0, 1'b0, 1'b1); tick(); tick(); tick();

    // Saturation of the 2-bit counter (0x00/p0 is bad under odd parity).
    for (int i = 0; i < 5; i++) begin
      drive(8'h00, 1'b0, 1'b1, 1'b1); tick();
    end
    // Clear coinciding with a bad word for the odd-parity instance.
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    // Clear coinciding with a bad word for the even-parity instance.
    drive(8'h03, 1'b1, 1'b1, 1'b1);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 1'b1); tick();
    err_clear = 1'b1; tick(); err_clear = 1'b0;

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      drive(8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0));
      err_clear = ($urandom_range(0, 24) == 0);
      tick();
    end
    err_clear = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 1'b1); tick(); tick(); tick();

    // Reset mid-stream with a full buffer and err_count=5.
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(8'h03, 1'b1, 1'b1, 1'b1); tick();
    end
    drive(8'h11, 1'b0, 1'b1, 1'b0); tick();
    drive(8'h22, 1'b0, 1'b1, 1'b0); tick();
    #3 rst_n = 1'b0;
    #1 check_reset();
    model_reset();
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 check_reset();
    #2 rst_n = 1'b1;
    drive(8'h0F, 1'b0, 1'b1, 1'b1); tick();
    drive(8'h00, 1'b0, 1'b0, 1'b1); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
